mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the 5-stage RV64 core. Consumes the EX/MEM pipeline register outputs, runs loads/stores over a
//  valid/ready data-memory port, sign/zero-extends load data, and presents results to the MEM/WB register.
//  Drives stall_MEM to freeze PC/IF_ID/ID_EX/EX_MEM while an access is outstanding.
// PARAMETERS
//  XLEN      64  data/address width
//  RID_W     5   register index width
//  INST_W    32  instruction width
// PORTS
//  clk              in   1       clock, rising edge
//  rst              in   1       asynchronous, active-low reset
//  flush_MEM        in   1       1 = slot is a bubble
//  rd_MEM           in   RID_W   destination register
//  wb_en_MEM        in   1       instruction writes rd
//  is_load          in   1       memory read
//  is_store         in   1       memory write (never both with is_load)
//  ld_unsigned      in   1       zero-extend load
//  mem_size         in   2       0=B 1=H 2=W 3=D
//  alu_result_MEM   in   XLEN    effective address / ALU result
//  store_data_MEM   in   XLEN    rs2 value, low bytes significant
//  pc_MEM           in   XLEN    debug pass-through
//  inst_MEM         in   INST_W  debug pass-through
//  stall_MEM        out  1       freeze upstream stages
//  dmem_req_valid   out  1       request valid
//  dmem_req_ready   in   1       memory accepts request
//  dmem_req_wen     out  1       1 = write
//  dmem_req_addr    out  XLEN    {alu_result_MEM[XLEN-1:3],3'b0}
//  dmem_req_wdata   out  XLEN    store data shifted to byte lane
//  dmem_req_wstrb   out  8       byte enables (0 on reads)
//  dmem_resp_valid  in   1       read data / write ack, one per request
//  dmem_resp_rdata  in   XLEN    aligned 8-byte read data
//  wb_en_out, rd_out, wb_data_out[XLEN], pc_out, inst_out, flush_out   out   to MEM/WB
//  misalign_o       out  1       access not naturally aligned
// BEHAVIOUR
//  - Mem op = ~flush_MEM & (is_load|is_store) & aligned. Aligned: addr[size-1:0]==0 (B always aligned).
//  - FSM: IDLE, REQ, RESP, DONE. Reset (async): state=IDLE, rdata_q=0; all outputs evaluate from IDLE.
//  - IDLE: non-mem or bubble -> combinational pass-through, wb_data_out=alu_result_MEM, stall_MEM=0, 0-cycle.
//    Mem op -> req_valid=1, stall_MEM=1; req_ready ? RESP : REQ.
//  - REQ: req_valid=1, addr/wdata/wstrb/wen stable (inputs frozen by stall), stall=1; req_ready -> RESP.
//  - RESP: req_valid=0, stall=1; resp_valid -> capture rdata into rdata_q, go DONE. resp_valid in IDLE/REQ ignored.
//  - DONE: stall=0, wb_data_out = extended rdata_q (loads) or alu_result_MEM (stores); next state IDLE.
//  - Min mem-op latency: 3 cycles (IDLE accept, RESP, DONE); each ready/resp wait adds 1.
//  - Load extract: byte offset addr[2:0], field width 8<<size, sign-extend from field MSB unless
//    ld_unsigned; D ignores ld_unsigned.
//  - Store: wdata = store_data << (8*addr[2:0]); wstrb = ((1<<(1<<size))-1) << addr[2:0].
//  - wb_en_out = wb_en_MEM & ~flush_MEM & ~stall_MEM & ~misalign_o; rd/pc/inst/flush pass through.
//  - Misaligned (non-bubble mem op): no request, misalign_o=1 for that cycle, stall=0, wb_en_out=0.
//  - flush_MEM only sampled in IDLE; an accepted access always completes (no abort).
//  - rst low mid-access: immediate IDLE, req_valid/stall drop asynchronously; late resp ignored.
//  - Output values meaningful only when stall_MEM=0.
// TESTING
//  - ALU op, alu_result=0x1234 -> wb_data_out=0x1234, wb_en_out=1, stall=0 same cycle, no req.
//  - LB addr=0x1003, ready=1, resp next cycle rdata=0x00000000_80000000 -> stall 2 cycles, wb_data=0xFFFF_FFFF_FFFF_FF80; LBU -> 0x80.
//  - SH addr=0x1006 data=0xBEEF, ready low 3 cycles -> req held stable, wstrb=0xC0,
//    wdata=0xBEEF<<48, wb_en=0.
//  - LW addr=0x1002 -> misalign_o=1 one cycle, no req_valid, wb_en_out=0.
//  - flush_MEM=1 with is_load -> no req, stall=0, wb_en_out=0.
//  - rst low in RESP -> state IDLE, req_valid=0, stall=0; resp_valid after reset release ignored.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage: drives loads/stores over a valid/ready data-memory port and extends load data for writeback.
// Non-memory ops pass through in 0 cycles; memory ops hold stall_MEM through REQ/RESP and release in DONE.
module mem_access_stage #(
  parameter int XLEN   = 64,
  parameter int RID_W  = 5,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_MEM,
  input  logic [RID_W-1:0]  rd_MEM,
  input  logic              wb_en_MEM,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              ld_unsigned,
  input  logic [1:0]        mem_size,
  input  logic [XLEN-1:0]   alu_result_MEM,
  input  logic [XLEN-1:0]   store_data_MEM,
  input  logic [XLEN-1:0]   pc_MEM,
  input  logic [INST_W-1:0] inst_MEM,
  output logic              stall_MEM,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_wen,
  output logic [XLEN-1:0]   dmem_req_addr,
  output logic [XLEN-1:0]   dmem_req_wdata,
  output logic [7:0]        dmem_req_wstrb,
  input  logic              dmem_resp_valid,
  input  logic [XLEN-1:0]   dmem_resp_rdata,
  output logic              wb_en_out,
  output logic [RID_W-1:0]  rd_out,
  output logic [XLEN-1:0]   wb_data_out,
  output logic [XLEN-1:0]   pc_out,
  output logic [INST_W-1:0] inst_out,
  output logic              flush_out,
  output logic              misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic            aligned, is_mem, mem_op, in_idle;
  logic [2:0]      byte_off;
  logic [5:0]      bit_off;
  logic [7:0]      lane_mask;
  logic [XLEN-1:0] ld_shifted, ld_ext;

  assign byte_off = alu_result_MEM[2:0];
  assign bit_off  = {byte_off, 3'b000};
  assign in_idle  = (state_q == IDLE);
  assign is_mem   = ~flush_MEM & (is_load | is_store);
  assign mem_op   = is_mem & aligned;

  always_comb begin
    aligned   = 1'b1;
    lane_mask = 8'h01;
    case (mem_size)
      2'd0: begin aligned = 1'b1;                 lane_mask = 8'h01; end
      2'd1: begin aligned = ~byte_off[0];         lane_mask = 8'h03; end
      2'd2: begin aligned = (byte_off[1:0] == 0); lane_mask = 8'h0F; end
      default: begin aligned = (byte_off == 0);   lane_mask = 8'hFF; end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (mem_op) state_d = dmem_req_ready ? RESP : REQ;
      REQ:  if (dmem_req_ready) state_d = RESP;
      RESP: if (dmem_resp_valid) begin
        state_d = DONE;
        rdata_d = dmem_resp_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  // Load extraction: move the addressed field down to bit 0, then extend from its MSB.
  always_comb begin
    ld_shifted = rdata_q >> bit_off;
    ld_ext     = ld_shifted;
    case (mem_size)
      2'd0: ld_ext = ld_unsigned ? {{(XLEN-8){1'b0}}, ld_shifted[7:0]}
                                 : {{(XLEN-8){ld_shifted[7]}}, ld_shifted[7:0]};
      2'd1: ld_ext = ld_unsigned ? {{(XLEN-16){1'b0}}, ld_shifted[15:0]}
                                 : {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
      2'd2: ld_ext = ld_unsigned ? {{(XLEN-32){1'b0}}, ld_shifted[31:0]}
                                 : {{(XLEN-32){ld_shifted[31]}}, ld_shifted[31:0]};
      default: ld_ext = ld_shifted;
    endcase
  end

  // Reset gates the handshake outputs so an in-flight request drops without waiting for a clock.
  always_comb begin
    dmem_req_valid = rst & ((in_idle & mem_op) | (state_q == REQ));
    stall_MEM      = rst & ((in_idle & mem_op) | (state_q == REQ) | (state_q == RESP));
    misalign_o     = in_idle & is_mem & ~aligned;
    dmem_req_wen   = is_store;
    dmem_req_addr  = {alu_result_MEM[XLEN-1:3], 3'b000};
    dmem_req_wdata = store_data_MEM << bit_off;
    dmem_req_wstrb = is_store ? (lane_mask << byte_off) : 8'h00;
    wb_data_out    = ((state_q == DONE) && is_load) ? ld_ext : alu_result_MEM;
    wb_en_out      = wb_en_MEM & ~flush_MEM & ~stall_MEM & ~misalign_o;
    rd_out         = rd_MEM;
    pc_out         = pc_MEM;
    inst_out       = inst_MEM;
    flush_out      = flush_MEM;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: writeback results go through a scoreboard, memory requests through a
// second expectation queue checked by the memory model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_MEM, wb_en_MEM, is_load, is_store, ld_unsigned;
  logic [4:0]  rd_MEM;
  logic [1:0]  mem_size;
  logic [63:0] alu_result_MEM, store_data_MEM, pc_MEM;
  logic [31:0] inst_MEM;
  logic        stall_MEM, dmem_req_valid, dmem_req_ready, dmem_req_wen;
  logic [63:0] dmem_req_addr, dmem_req_wdata, dmem_resp_rdata, wb_data_out, pc_out;
  logic [7:0]  dmem_req_wstrb;
  logic        dmem_resp_valid;
  logic        wb_en_out, flush_out, misalign_o;
  logic [4:0]  rd_out;
  logic [31:0] inst_out;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst(rst), .flush_MEM(flush_MEM), .rd_MEM(rd_MEM), .wb_en_MEM(wb_en_MEM),
    .is_load(is_load), .is_store(is_store), .ld_unsigned(ld_unsigned), .mem_size(mem_size),
    .alu_result_MEM(alu_result_MEM), .store_data_MEM(store_data_MEM), .pc_MEM(pc_MEM),
    .inst_MEM(inst_MEM), .stall_MEM(stall_MEM), .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready), .dmem_req_wen(dmem_req_wen), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .wb_en_out(wb_en_out), .rd_out(rd_out), .wb_data_out(wb_data_out), .pc_out(pc_out),
    .inst_out(inst_out), .flush_out(flush_out), .misalign_o(misalign_o)
  );

  typedef struct { logic en; logic [63:0] data; logic chk_data; logic mis; logic [4:0] rd; logic [63:0] pc; } wb_exp_t;
  typedef struct { logic [63:0] addr; logic wen; logic [7:0] strb; logic [63:0] wdata; } req_exp_t;

  wb_exp_t  sb[$];
  req_exp_t rq[$];

  int total = 0;
  int bad   = 0;
  logic        instr_vld  = 1'b0;
  logic        mem_silent = 1'b0;
  int          ready_wait = 0;
  int          resp_wait  = 0;
  logic [63:0] cur_rdata  = '0;
  int          op_idx     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Writeback monitor: one pop per instruction, on the cycle it leaves the stage.
  initial begin
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (rst && instr_vld && !stall_MEM) begin
        if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          chk("wb_en", {63'd0, wb_en_out}, {63'd0, e.en});
          chk("misalign", {63'd0, misalign_o}, {63'd0, e.mis});
          chk("rd_out", {59'd0, rd_out}, {59'd0, e.rd});
          chk("pc_out", pc_out, e.pc);
          if (e.chk_data) chk("wb_data", wb_data_out, e.data);
        end
      end
    end
  end

  // Memory model: programmable ready wait and response wait; checks every request cycle against the queue head.
  initial begin
    int w = 0;
    int pend = 0;
    logic [63:0] pend_rdata = '0;
    logic accepted;
    forever begin
      @(negedge clk);
      if (!mem_silent) dmem_resp_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0 && !mem_silent) begin
          dmem_resp_valid = 1'b1;
          dmem_resp_rdata = pend_rdata;
        end
      end
      if (dmem_req_valid) begin
        accepted = 1'b0;
        if (rq.size() == 0) chk("unexpected_req", 64'd1, 64'd0);
        else begin
          chk("req_addr", dmem_req_addr, rq[0].addr);
          chk("req_wen", {63'd0, dmem_req_wen}, {63'd0, rq[0].wen});
          chk("req_wstrb", {56'd0, dmem_req_wstrb}, {56'd0, rq[0].strb});
          if (rq[0].wen) chk("req_wdata", dmem_req_wdata, rq[0].wdata);
        end
        if (dmem_req_ready) accepted = 1'b1;
        else if (w >= ready_wait) begin
          dmem_req_ready = 1'b1;
          accepted = 1'b1;
        end else w++;
        if (accepted) begin
          w = 0;
          pend = 1 + resp_wait;
          pend_rdata = cur_rdata;
          if (rq.size() != 0) void'(rq.pop_front());
        end
      end
    end
  end

  task automatic op(input logic ld, input logic st, input logic uns, input logic [1:0] sz,
                    input logic [63:0] addr, input logic [63:0] sdata, input logic [63:0] rdata,
                    input logic wben, input logic flush, input int rw, input int rwp,
                    input logic exp_en, input logic [63:0] exp_data, input logic chk_data,
                    input logic exp_mis, input logic exp_req, input logic [7:0] exp_strb,
                    input logic [63:0] exp_wdata, input int lat);
    wb_exp_t  e;
    req_exp_t r;
    int       stalls = 0;
    logic     done = 1'b0;
    op_idx++;
    is_load = ld; is_store = st; ld_unsigned = uns; mem_size = sz;
    alu_result_MEM = addr; store_data_MEM = sdata; wb_en_MEM = wben; flush_MEM = flush;
    rd_MEM = 5'(op_idx); pc_MEM = 64'h8000_0000 + 64'(op_idx * 4); inst_MEM = 32'(op_idx);
    ready_wait = rw; resp_wait = rwp; cur_rdata = rdata;
    dmem_req_ready = (rw == 0);
    e.en = exp_en; e.data = exp_data; e.chk_data = chk_data; e.mis = exp_mis;
    e.rd = 5'(op_idx); e.pc = 64'h8000_0000 + 64'(op_idx * 4);
    sb.push_back(e);
    if (exp_req) begin
      r.addr = {addr[63:3], 3'b000}; r.wen = st; r.strb = exp_strb; r.wdata = exp_wdata;
      rq.push_back(r);
    end
    instr_vld = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!stall_MEM) done = 1'b1;
      else stalls++;
    end
    if (!done) chk("stall_timeout", 64'd1, 64'd0);
    chk("stall_cycles", 64'(stalls), 64'(lat));
    @(posedge clk); #1;
    instr_vld = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    flush_MEM = 0; wb_en_MEM = 0; is_load = 0; is_store = 0; ld_unsigned = 0; rd_MEM = 0;
    mem_size = 0; alu_result_MEM = 0; store_data_MEM = 0; pc_MEM = 0; inst_MEM = 0;
    dmem_req_ready = 1'b1; dmem_resp_valid = 1'b0; dmem_resp_rdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_stall", {63'd0, stall_MEM}, 64'd0);
    chk("reset_req_valid", {63'd0, dmem_req_valid}, 64'd0);
    @(posedge clk); #1 rst = 1'b1;

    //  ld st un sz  addr       sdata                  rdata                  wb fl rw rp  en data                    cd mis rq strb   wdata                  lat
    op(0, 0, 0, 0, 64'h1234, 64'h0, 64'h0,                  1, 0, 0, 0,  1, 64'h1234,                1, 0, 0, 8'h00, 64'h0,                 0);
    op(1, 0, 0, 0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 1, 0, 0, 0,  1, 64'hFFFF_FFFF_FFFF_FF80, 1, 0, 1, 8'h00, 64'h0,                 2);
    op(1, 0, 1, 0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 1, 0, 0, 0,  1, 64'h80,                  1, 0, 1, 8'h00, 64'h0,                 2);
    op(0, 1, 0, 1, 64'h1006, 64'hBEEF, 64'h0,               0, 0, 3, 0,  0, 64'h1006,                1, 0, 1, 8'hC0, 64'hBEEF_0000_0000_0000, 5);
    op(1, 0, 0, 2, 64'h1002, 64'h0, 64'h0,                  1, 0, 0, 0,  0, 64'h0,                   0, 1, 0, 8'h00, 64'h0,                 0);
    op(1, 0, 0, 2, 64'h1001, 64'h0, 64'h0,                  1, 1, 0, 0,  0, 64'h1001,                1, 0, 0, 8'h00, 64'h0,                 0);
    op(1, 0, 0, 1, 64'h100E, 64'h0, 64'h8001_0000_0000_0000, 1, 0, 0, 2,  1, 64'hFFFF_FFFF_FFFF_8001, 1, 0, 1, 8'h00, 64'h0,                 4);
    op(1, 0, 1, 2, 64'h1004, 64'h0, 64'hCAFE_BABE_0000_0000, 1, 0, 1, 0,  1, 64'h0000_0000_CAFE_BABE, 1, 0, 1, 8'h00, 64'h0,                 3);
    op(1, 0, 0, 2, 64'h1004, 64'h0, 64'hCAFE_BABE_0000_0000, 1, 0, 0, 0,  1, 64'hFFFF_FFFF_CAFE_BABE, 1, 0, 1, 8'h00, 64'h0,                 2);
    op(1, 0, 1, 3, 64'h1008, 64'h0, 64'h8123_4567_89AB_CDEF, 1, 0, 0, 0,  1, 64'h8123_4567_89AB_CDEF, 1, 0, 1, 8'h00, 64'h0,                 2);
    op(1, 0, 0, 1, 64'h1001, 64'h0, 64'h0,                  1, 0, 0, 0,  0, 64'h0,                   0, 1, 0, 8'h00, 64'h0,                 0);
    op(0, 1, 0, 0, 64'h1001, 64'h1234_56AB, 64'h0,          0, 0, 0, 0,  0, 64'h1001,                1, 0, 1, 8'h02, 64'h0000_0012_3456_AB00, 2);
    op(0, 1, 0, 3, 64'h2000, 64'h1122_3344_5566_7788, 64'h0, 0, 0, 0, 1,  0, 64'h2000,                1, 0, 1, 8'hFF, 64'h1122_3344_5566_7788, 3);
    op(0, 1, 0, 2, 64'h2004, 64'hDEAD_BEEF, 64'h0,          0, 0, 0, 0,  0, 64'h2004,                1, 0, 1, 8'hF0, 64'hDEAD_BEEF_0000_0000, 2);
    op(0, 1, 0, 3, 64'h2004, 64'h0, 64'h0,                  0, 0, 0, 0,  0, 64'h0,                   0, 1, 0, 8'h00, 64'h0,                 0);

    // Reset while the access waits in RESP; the memory holds its response until after release.
    begin
      req_exp_t r;
      mem_silent = 1'b1; ready_wait = 0; resp_wait = 0; dmem_req_ready = 1'b1;
      is_load = 1; is_store = 0; ld_unsigned = 0; mem_size = 0; flush_MEM = 0; wb_en_MEM = 1;
      alu_result_MEM = 64'h1005; rd_MEM = 5'd30; pc_MEM = 64'h9000;
      r.addr = 64'h1000; r.wen = 1'b0; r.strb = 8'h00; r.wdata = '0;
      rq.push_back(r);
      @(negedge clk);
      @(negedge clk);
      chk("resp_wait_stall", {63'd0, stall_MEM}, 64'd1);
      chk("resp_wait_req_valid", {63'd0, dmem_req_valid}, 64'd0);
      rst = 1'b0;
      #1;
      chk("async_rst_stall", {63'd0, stall_MEM}, 64'd0);
      chk("async_rst_req_valid", {63'd0, dmem_req_valid}, 64'd0);
      @(posedge clk); #1;
      flush_MEM = 1'b1; alu_result_MEM = 64'h55;
      @(posedge clk); #1;
      rst = 1'b1;
      begin
        wb_exp_t e;
        e.en = 1'b0; e.data = 64'h55; e.chk_data = 1'b1; e.mis = 1'b0; e.rd = 5'd30; e.pc = 64'h9000;
        sb.push_back(e);
      end
      dmem_resp_valid = 1'b1; dmem_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      instr_vld = 1'b1;
      @(posedge clk); #1;
      instr_vld = 1'b0; dmem_resp_valid = 1'b0;
      @(negedge clk);
      chk("late_resp_stall", {63'd0, stall_MEM}, 64'd0);
      chk("late_resp_wb_data", wb_data_out, 64'h55);
      mem_silent = 1'b0;
      @(posedge clk); #1;
    end

    op(0, 0, 0, 0, 64'hABCD, 64'h0, 64'h0, 1, 0, 0, 0, 1, 64'hABCD, 1, 0, 0, 8'h00, 64'h0, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("req_drained", 64'(rq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
